// File: rtl/eeg_fram_seq_if.sv
// eeg_fram_seq_if: job, FRAM configuration and per-lane address bundle for the FRAM sequencer
interface eeg_fram_seq_if #(
    parameter int NUM_DW = 4,
    parameter int ADD_AW = 12,
    parameter int CMD_DW = 4,
    parameter int LEN_AW = 12
);
    logic                     JOB_VLD;
    logic                     JOB_RDY;
    logic [CMD_DW-1:0]        JOB_CMD;
    logic                     JOB_FLG;
    logic [ADD_AW-1:0]        JOB_BASE;
    logic [ADD_AW-1:0]        JOB_STRD;
    logic [LEN_AW-1:0]        JOB_LEN;
    logic                     JOB_DONE;
    logic                     JOB_ERR;
    logic                     FRAM_IDLE;
    logic                     CFG_INFO_VLD;
    logic                     CFG_INFO_RDY;
    logic [CMD_DW-1:0]        CFG_INFO_CMD;
    logic                     CFG_FLAG_VLD;
    logic [NUM_DW-1:0]        ADD_VLD;
    logic [NUM_DW-1:0]        ADD_LST;
    logic [NUM_DW-1:0]        ADD_END;
    logic [NUM_DW-1:0]        ADD_RDY;
    logic [NUM_DW*ADD_AW-1:0] ADD_ADD;
    modport master (
        input  JOB_VLD, JOB_CMD, JOB_FLG, JOB_BASE, JOB_STRD, JOB_LEN, FRAM_IDLE, CFG_INFO_RDY, ADD_RDY,
        output JOB_RDY, JOB_DONE, JOB_ERR, CFG_INFO_VLD, CFG_INFO_CMD, CFG_FLAG_VLD, ADD_VLD, ADD_LST, ADD_END, ADD_ADD
    );
    modport slave (
        output JOB_VLD, JOB_CMD, JOB_FLG, JOB_BASE, JOB_STRD, JOB_LEN, FRAM_IDLE, CFG_INFO_RDY, ADD_RDY,
        input  JOB_RDY, JOB_DONE, JOB_ERR, CFG_INFO_VLD, CFG_INFO_CMD, CFG_FLAG_VLD, ADD_VLD, ADD_LST, ADD_END, ADD_ADD
    );
endinterface

// File: rtl/eeg_fram_seq.sv
// eeg_fram_seq: job sequencer that configures the FRAM and streams per-lane addresses
module eeg_fram_seq #(
    parameter int NUM_DW = 4,
    parameter int ADD_AW = 12,
    parameter int CMD_DW = 4,
    parameter int LEN_AW = 12
) (
    input logic            clk,
    input logic            rst_n,
    eeg_fram_seq_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_CFG = 3'd1, S_RUN = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
    localparam logic [CMD_DW-1:0] C_IDLE = CMD_DW'(1), C_ITOF = CMD_DW'(2), C_CONV = CMD_DW'(4), C_OTOF = CMD_DW'(8);
    logic [2:0]        st;
    logic [CMD_DW-1:0] cmd;
    logic              flg, err, done;
    logic [ADD_AW-1:0] base, strd;
    logic [LEN_AW-1:0] len;
    logic [NUM_DW-1:0] vld, lst, aend, vld_nxt;
    logic [ADD_AW-1:0] add [NUM_DW];
    logic [LEN_AW-1:0] cnt [NUM_DW];
    logic              accept, cfg_hs, legal;

    // the DONE pulse is registered, so hold off the next job until it has gone
    assign bus.JOB_RDY      = rst_n && st == S_IDLE && !done;
    assign accept           = bus.JOB_VLD && bus.JOB_RDY;
    assign legal            = bus.JOB_CMD inside {C_ITOF, C_CONV, C_OTOF};
    assign bus.CFG_INFO_VLD = st == S_CFG && bus.FRAM_IDLE;
    assign cfg_hs           = bus.CFG_INFO_VLD && bus.CFG_INFO_RDY;
    assign vld_nxt          = vld & ~(bus.ADD_RDY & lst);
    assign bus.CFG_INFO_CMD = cmd;
    assign bus.CFG_FLAG_VLD = flg;
    assign bus.JOB_DONE     = done;
    assign bus.JOB_ERR      = done && err;
    assign bus.ADD_VLD      = vld;
    assign bus.ADD_LST      = lst;
    assign bus.ADD_END      = aend;

    genvar i;
    for (i = 0; i < NUM_DW; i++) begin : g_add
        assign bus.ADD_ADD[i*ADD_AW +: ADD_AW] = add[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            cmd  <= C_IDLE;
            flg  <= 1'b0;
            err  <= 1'b0;
            done <= 1'b0;
            base <= '0;
            strd <= '0;
            len  <= '0;
        end else begin
            done <= st == S_DONE;
            case (st)
                S_IDLE: if (accept) begin
                    cmd  <= bus.JOB_CMD;
                    flg  <= bus.JOB_FLG;
                    base <= bus.JOB_BASE;
                    strd <= bus.JOB_STRD;
                    len  <= bus.JOB_LEN;
                    err  <= !legal;
                    st   <= legal ? S_CFG : S_DONE;
                end
                S_CFG:   if (cfg_hs) st <= cmd == C_ITOF ? S_DRAIN : S_RUN;
                S_RUN:   if (vld_nxt == '0) st <= S_DRAIN;
                S_DRAIN: if (bus.FRAM_IDLE) st <= S_DONE;
                default: st <= S_IDLE;
            endcase
        end
    end

    // the address register walks BASE + i*STRD + cnt by incrementing, wrapping at ADD_AW bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            lst  <= '0;
            aend <= '0;
            for (int k = 0; k < NUM_DW; k++) begin
                add[k] <= '0;
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DW; k++) begin
                if (accept) begin
                    cnt[k] <= '0;
                end else if (cfg_hs && cmd != C_ITOF) begin
                    vld[k]  <= 1'b1;
                    add[k]  <= base + strd * ADD_AW'(k);
                    lst[k]  <= len == '0;
                    aend[k] <= len == '0 && cmd == C_CONV;
                end else if (vld[k] && bus.ADD_RDY[k]) begin
                    cnt[k]  <= cnt[k] + LEN_AW'(1);
                    add[k]  <= add[k] + ADD_AW'(1);
                    vld[k]  <= !lst[k];
                    lst[k]  <= !lst[k] && cnt[k] + LEN_AW'(1) == len;
                    aend[k] <= !lst[k] && cnt[k] + LEN_AW'(1) == len && cmd == C_CONV;
                end
            end
        end
    end
endmodule

// File: tb/tb_eeg_fram_seq.sv
// tb_eeg_fram_seq: scoreboard bench for the FRAM job sequencer with a small FRAM busy model
module tb_eeg_fram_seq;
    typedef struct packed {
        logic [11:0] a;
        logic        l;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fram_idle = 1'b1;
    logic        hold_busy = 1'b0;
    logic        fram_hs;
    int          busy_cnt = 0;
    int          busy_len = 4;
    int          checks = 0;
    int          errors = 0;
    beat_t       lq [4][$];
    logic [4:0]  cq [$];
    logic        dq [$];
    logic [3:0]  prev_stall = '0;
    logic [11:0] prev_a [4];
    logic [1:0]  prev_le [4];
    logic [11:0] cur_a;
    beat_t       bt;
    logic [4:0]  ce;
    logic        de;

    eeg_fram_seq_if bus ();
    eeg_fram_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.FRAM_IDLE = fram_idle;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FRAM leaves idle right after a config handshake and stays busy busy_len cycles
    always @(posedge clk) begin
        fram_hs = bus.CFG_INFO_VLD && bus.CFG_INFO_RDY;
        #2;
        if (!rst_n) busy_cnt = 0;
        else if (fram_hs) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        fram_idle = !(hold_busy || busy_cnt > 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = '0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                cur_a = bus.ADD_ADD[l*12 +: 12];
                if (prev_stall[l]) begin
                    chk($sformatf("lane%0d_hold_vld", l), 32'(bus.ADD_VLD[l]), 1);
                    chk($sformatf("lane%0d_hold_addr", l), 32'(cur_a), 32'(prev_a[l]));
                    chk($sformatf("lane%0d_hold_lst_end", l), 32'({bus.ADD_LST[l], bus.ADD_END[l]}), 32'(prev_le[l]));
                end
                if (bus.ADD_VLD[l] && bus.ADD_RDY[l]) begin
                    chk($sformatf("lane%0d_beat_expected", l), 32'(lq[l].size() > 0), 1);
                    if (lq[l].size() > 0) begin
                        bt = lq[l].pop_front();
                        chk($sformatf("lane%0d_addr", l), 32'(cur_a), 32'(bt.a));
                        chk($sformatf("lane%0d_lst", l), 32'(bus.ADD_LST[l]), 32'(bt.l));
                        chk($sformatf("lane%0d_end", l), 32'(bus.ADD_END[l]), 32'(bt.e));
                    end
                end
                prev_stall[l] = bus.ADD_VLD[l] && !bus.ADD_RDY[l];
                prev_a[l]     = cur_a;
                prev_le[l]    = {bus.ADD_LST[l], bus.ADD_END[l]};
            end
            if (bus.CFG_INFO_VLD && bus.CFG_INFO_RDY) begin
                chk("cfg_expected", 32'(cq.size() > 0), 1);
                if (cq.size() > 0) begin
                    ce = cq.pop_front();
                    chk("cfg_cmd", 32'(bus.CFG_INFO_CMD), 32'(ce[4:1]));
                    chk("cfg_flag", 32'(bus.CFG_FLAG_VLD), 32'(ce[0]));
                end
            end
            if (bus.JOB_DONE) begin
                chk("done_expected", 32'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    de = dq.pop_front();
                    chk("job_err", 32'(bus.JOB_ERR), 32'(de));
                end
                chk("done_lanes_drained", 32'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()), 0);
                chk("done_fram_idle", 32'(bus.FRAM_IDLE), 1);
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic f, input logic [11:0] b,
                         input logic [11:0] s, input logic [11:0] n);
        beat_t x;
        bit    ok;
        int    t;
        ok = (c == 4'b0010 || c == 4'b0100 || c == 4'b1000);
        if (ok) cq.push_back({c, f});
        if (ok && c != 4'b0010)
            for (int l = 0; l < 4; l++)
                for (int k = 0; k <= int'(n); k++) begin
                    x.a = b + s * 12'(l) + 12'(k);
                    x.l = (k == int'(n));
                    x.e = x.l && c == 4'b0100;
                    lq[l].push_back(x);
                end
        dq.push_back(!ok);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!bus.JOB_RDY && t < 100);
        chk("job_rdy_wait", 32'(bus.JOB_RDY), 1);
        bus.JOB_VLD  = 1'b1;
        bus.JOB_CMD  = c;
        bus.JOB_FLG  = f;
        bus.JOB_BASE = b;
        bus.JOB_STRD = s;
        bus.JOB_LEN  = n;
        @(posedge clk); #1;
        bus.JOB_VLD = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (dq.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("job_done_timeout", 32'(dq.size()), 0);
    endtask

    initial begin
        int t;
        bus.JOB_VLD      = 1'b0;
        bus.JOB_CMD      = '0;
        bus.JOB_FLG      = 1'b0;
        bus.JOB_BASE     = '0;
        bus.JOB_STRD     = '0;
        bus.JOB_LEN      = '0;
        bus.CFG_INFO_RDY = 1'b1;
        bus.ADD_RDY      = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_job_rdy", 32'(bus.JOB_RDY), 0);
        chk("rst_job_done", 32'(bus.JOB_DONE), 0);
        chk("rst_job_err", 32'(bus.JOB_ERR), 0);
        chk("rst_cfg_vld", 32'(bus.CFG_INFO_VLD), 0);
        chk("rst_cfg_cmd", 32'(bus.CFG_INFO_CMD), 1);
        chk("rst_cfg_flag", 32'(bus.CFG_FLAG_VLD), 0);
        chk("rst_add_vld", 32'(bus.ADD_VLD), 0);
        chk("rst_add_lst_end", 32'({bus.ADD_LST, bus.ADD_END}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_job_rdy", 32'(bus.JOB_RDY), 1);

        busy_len = 6;
        issue(4'b1000, 1'b0, 12'h100, 12'h040, 12'd3);
        wait_done();

        busy_len = 2;
        bus.ADD_RDY = 4'b1011;
        issue(4'b0100, 1'b1, 12'h080, 12'h010, 12'd0);
        t = 0;
        while (!bus.ADD_VLD[2] && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("conv_l2_stall_vld", 32'(bus.ADD_VLD[2]), 1);
            chk("conv_l2_stall_addr", 32'(bus.ADD_ADD[24 +: 12]), 32'h0A0);
            chk("conv_l2_stall_lst_end", 32'({bus.ADD_LST[2], bus.ADD_END[2]}), 32'b11);
        end
        @(posedge clk); #1;
        bus.ADD_RDY = 4'hF;
        wait_done();

        busy_len = 3;
        hold_busy = 1'b1;
        @(posedge clk); #1;
        issue(4'b0010, 1'b0, 12'h123, 12'h001, 12'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("itof_cfg_held_off", 32'(bus.CFG_INFO_VLD), 0);
        end
        @(posedge clk); #1;
        hold_busy = 1'b0;
        t = 0;
        while (dq.size() > 0 && t < 100) begin
            @(negedge clk);
            chk("itof_no_add_vld", 32'(bus.ADD_VLD), 0);
            t++;
        end
        chk("itof_done_timeout", 32'(dq.size()), 0);

        issue(4'b0011, 1'b0, 12'h000, 12'h000, 12'd0);
        @(negedge clk);
        chk("err_c1_done", 32'(bus.JOB_DONE), 0);
        chk("err_c1_cfg_vld", 32'(bus.CFG_INFO_VLD), 0);
        @(negedge clk);
        chk("err_c2_done", 32'(bus.JOB_DONE), 1);
        chk("err_c2_err", 32'(bus.JOB_ERR), 1);
        chk("err_c2_rdy", 32'(bus.JOB_RDY), 0);
        chk("err_c2_cfg_vld", 32'(bus.CFG_INFO_VLD), 0);
        @(negedge clk);
        chk("err_c3_rdy", 32'(bus.JOB_RDY), 1);
        chk("err_c3_done", 32'(bus.JOB_DONE), 0);
        wait_done();

        busy_len = 2;
        issue(4'b1000, 1'b0, 12'hFFE, 12'h001, 12'd2);
        wait_done();

        busy_len = 4;
        bus.ADD_RDY = 4'h0;
        issue(4'b1000, 1'b0, 12'h200, 12'h010, 12'd20);
        t = 0;
        while (bus.ADD_VLD != 4'hF && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_running", 32'(bus.ADD_VLD), 32'hF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_add_vld", 32'(bus.ADD_VLD), 0);
        chk("midrst_cfg_vld", 32'(bus.CFG_INFO_VLD), 0);
        chk("midrst_job_rdy", 32'(bus.JOB_RDY), 0);
        chk("midrst_add_lst", 32'(bus.ADD_LST), 0);
        for (int l = 0; l < 4; l++) lq[l].delete();
        dq.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ADD_RDY = 4'hF;
        @(negedge clk);
        chk("midrst_rel_rdy", 32'(bus.JOB_RDY), 1);
        chk("midrst_rel_cmd", 32'(bus.CFG_INFO_CMD), 1);
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.JOB_DONE), 0);
        end

        issue(4'b0100, 1'b1, 12'h3FF, 12'h100, 12'd0);
        wait_done();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eeg_fram_seq.md
Name: eeg_fram_seq

Overview:
Job-level sequencer for the multi-lane feature RAM (FRAM). It accepts one job descriptor at a time and issues the matching configuration command to the FRAM only while the FRAM is idle. For read-type jobs it generates per-lane address streams with last/end marking. It then waits for the FRAM to return to idle and signals completion, so upstream control sees one handshake per FRAM operation.

Parameters:
NUM_DW, 4, number of FRAM lanes
ADD_AW, 12, address width per lane
CMD_DW, 4, command width (one-hot: 0001 IDLE, 0010 ITOF, 0100 CONV, 1000 OTOF)
LEN_AW, 12, width of per-lane beat count field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
JOB_VLD  in  1  job descriptor valid
JOB_RDY  out  1  sequencer can accept a job
JOB_CMD  in  CMD_DW  FRAM command for the job
JOB_FLG  in  1  data-valid flag forwarded as CFG_FLAG_VLD
JOB_BASE  in  ADD_AW  lane-0 start address
JOB_STRD  in  ADD_AW  address offset between adjacent lanes
JOB_LEN  in  LEN_AW  beats per lane minus 1
JOB_DONE  out  1  one-cycle pulse when the job completes
JOB_ERR  out  1  one-cycle pulse, same cycle as JOB_DONE, for an illegal command
FRAM_IDLE  in  1  FRAM idle status
CFG_INFO_VLD  out  1  command valid to FRAM
CFG_INFO_RDY  in  1  FRAM accepts command
CFG_INFO_CMD  out  CMD_DW  latched JOB_CMD
CFG_FLAG_VLD  out  1  latched JOB_FLG
ADD_VLD  out  NUM_DW  per-lane address valid
ADD_LST  out  NUM_DW  per-lane last address
ADD_END  out  NUM_DW  per-lane end marker (CONV jobs only)
ADD_RDY  in  NUM_DW  per-lane address ready
ADD_ADD  out  NUM_DW*ADD_AW  per-lane address; lane i occupies bits [i*ADD_AW +: ADD_AW]

Behaviour:
- Reset: state IDLE. JOB_RDY=0 during reset. JOB_DONE, JOB_ERR, CFG_INFO_VLD, ADD_VLD, ADD_LST and ADD_END are 0. CFG_INFO_CMD=0001, CFG_FLAG_VLD=0. Internal counters and the descriptor are 0.
- States: IDLE, CFG, RUN, DRAIN, DONE.
- IDLE:
  - JOB_RDY = 1 in IDLE only.
  - On JOB_VLD&JOB_RDY, latch the descriptor.
  - Legal command is exactly ITOF, CONV or OTOF: go to CFG.
  - Any other value: go to DONE with the error flag set. No CFG is issued.
- CFG:
  - CFG_INFO_VLD = FRAM_IDLE. It is held until CFG_INFO_VLD&CFG_INFO_RDY.
  - CFG_INFO_CMD and CFG_FLAG_VLD are stable from job accept until the next accept.
  - On the handshake: go to RUN for CONV/OTOF, or DRAIN for ITOF.
  - First ADD_VLD appears the cycle after the CFG handshake.
- RUN:
  - Each lane i has a beat counter cnt[i], cleared on job accept.
  - ADD_VLD[i] = 1 while lane i is not finished.
  - ADD_ADD[i] = (BASE + i*STRD + cnt[i]) mod 2^ADD_AW. Arithmetic is unsigned and truncated to ADD_AW.
  - ADD_LST[i] = (cnt[i]==LEN).
  - ADD_END[i] = ADD_LST[i] & (cmd==CONV).
  - On ADD_VLD[i]&ADD_RDY[i]: cnt[i] increments. If ADD_LST[i] is also set, lane i is finished and its ADD_VLD drops the next cycle.
  - Lanes progress independently. Address, LST and END stay stable while VLD=1 and RDY=0.
  - When all lanes are finished (including simultaneous last handshakes), go to DRAIN.
  - JOB_LEN=0 gives one beat per lane with ADD_LST set on the first beat.
- DRAIN:
  - Wait for FRAM_IDLE=1, then go to DONE.
  - The FRAM leaves idle the cycle after the CFG handshake, so the first DRAIN cycle never sees a stale idle.
- DONE:
  - JOB_DONE=1 for exactly one cycle; JOB_ERR=1 in the same cycle if the error flag is set.
  - Next state is IDLE. The next job is accepted no earlier than the cycle after JOB_DONE.
- Reset mid-operation: everything returns to reset values immediately. No JOB_DONE is generated and the in-flight job is dropped.
- ADD_* outputs are registered. CFG_INFO_VLD and JOB_RDY are state-decoded.

Test Plan:
- OTOF job, BASE=0x100, STRD=0x040, LEN=3, ADD_RDY=1111 -> lane0 issues 0x100..0x103 and lane3 issues 0x1C0..0x1C3. ADD_LST is set on the 4th beat of each lane, ADD_END stays 0. JOB_DONE pulses once after FRAM_IDLE returns high.
- CONV job, LEN=0, lane2 ADD_RDY held 0 for 5 cycles -> lanes 0, 1 and 3 finish in 1 beat with ADD_LST=ADD_END=1. Lane 2 holds address BASE+2*STRD stable for 5 cycles. DRAIN is entered only after lane 2's handshake.
- ITOF job with FRAM_IDLE=0 for 3 cycles before the CFG handshake -> CFG_INFO_VLD stays 0 for those 3 cycles. No ADD_VLD is ever asserted. JOB_DONE pulses after FRAM_IDLE returns to 1.
- JOB_CMD=0011 -> no CFG_INFO_VLD. JOB_DONE and JOB_ERR pulse together 2 cycles after accept. JOB_RDY=1 the following cycle.
- Wrap: BASE=0xFFE, STRD=0x001, LEN=2 -> lane0 issues 0xFFE, 0xFFF, 0x000 and lane1 issues 0xFFF, 0x000, 0x001.
- rst_n asserted mid-RUN -> ADD_VLD=0000 and CFG_INFO_VLD=0 immediately. State returns to IDLE with JOB_RDY=1 after release. No JOB_DONE pulse.
